// File: rtl/controller_burst_if.sv
// Bus interface for controller_burst: command/key inputs, strobes and status.
// The master modport is the command/transceiver side, the slave modport is the controller.
interface controller_burst_if #(
    parameter int BURST_LEN = 1
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic             ValidCmd;
    logic             RW;
    logic             InputKey;
    logic             TransferDone;
    logic             Busy;
    logic             Active;
    logic             Mode;
    logic             AccessMem;
    logic             RWMem;
    logic             SampleData;
    logic             TransferData;
    logic [CNT_W-1:0] BeatCount;
    logic             Error;

    modport master (
        output ValidCmd, RW, InputKey, TransferDone,
        input  Busy, Active, Mode, AccessMem, RWMem, SampleData, TransferData,
        input  BeatCount, Error
    );

    modport slave (
        input  ValidCmd, RW, InputKey, TransferDone,
        output Busy, Active, Mode, AccessMem, RWMem, SampleData, TransferData,
        output BeatCount, Error
    );
endinterface

// File: rtl/controller_burst.sv
// controller_burst: key-unlocked burst sequencer for memory/transceiver strobes.
// A serially entered key unlocks the controller and selects the mode; once active,
// each accepted command runs BURST_LEN beats (write: SAMPLE->MEM, read: MEM->XFER).
// Optional transfer watchdog: define CONTROLLER_BURST_WATCHDOG_EN.
module controller_burst #(
    parameter int                   KEY_WIDTH      = 4,
    parameter logic [KEY_WIDTH-1:0] KEY_MODE0      = KEY_WIDTH'(4'b1010),
    parameter logic [KEY_WIDTH-1:0] KEY_MODE1      = KEY_WIDTH'(4'b0101),
    parameter int                   BURST_LEN      = 1,
    parameter int                   IDLE_LIMIT     = 0,
    parameter int                   TIMEOUT_CYCLES = 16
) (
    input logic               Clk,
    input logic               Reset,
    controller_burst_if.slave bus
);
    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int KCNT_W = $clog2(KEY_WIDTH + 1);
    localparam int IDLE_W = (IDLE_LIMIT > 1) ? $clog2(IDLE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN);
    localparam logic [KCNT_W-1:0] LAST_KBIT = KCNT_W'(KEY_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, MEM, XFER} state_t;

    state_t               state;
    state_t               state_next;
    logic [KEY_WIDTH-1:0] key_sr;
    logic [KCNT_W-1:0]    key_cnt;
    logic [KEY_WIDTH:0]   key_ext;
    logic [KEY_WIDTH-1:0] key_word;
    logic                 key_last;
    logic                 key_mismatch;
    logic                 active;
    logic                 mode;
    logic                 error;
    logic                 rw_lat;
    logic [CNT_W-1:0]     beat_count;
    logic [CNT_W-1:0]     beat_next;
    logic                 accept;
    logic                 beat_done;
    logic                 wd_abort;
    logic                 idle_expire;

    // The word compared on the last key bit already includes that bit.
    assign key_ext      = {key_sr, bus.InputKey};
    assign key_word     = key_ext[KEY_WIDTH-1:0];
    assign key_last     = !active && bus.ValidCmd && (key_cnt == LAST_KBIT);
    assign key_mismatch = key_last && (key_word != KEY_MODE0) && (key_word != KEY_MODE1);
    assign beat_next    = beat_count + CNT_W'(1);

`ifdef CONTROLLER_BURST_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;

    // XFER dwell counter; held at zero outside XFER so every entry starts fresh.
    always_ff @(posedge Clk) begin
        if (Reset || state != XFER) wd_cnt <= '0;
        else                        wd_cnt <= wd_cnt + WD_W'(1);
    end
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode; commands are only taken while already sitting in IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        beat_done  = 1'b0;
        wd_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (active && bus.ValidCmd) begin
                    accept     = 1'b1;
                    state_next = bus.RW ? SAMPLE : MEM;
                end
            end
            SAMPLE: state_next = MEM;
            MEM: begin
                if (rw_lat) begin
                    beat_done  = 1'b1;
                    state_next = (beat_next < LAST_BEAT) ? SAMPLE : IDLE;
                end else begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (bus.TransferDone) begin
                    beat_done  = 1'b1;
                    state_next = (beat_next < LAST_BEAT) ? MEM : IDLE;
                end
`ifdef CONTROLLER_BURST_WATCHDOG_EN
                else if (wd_cnt == WD_LAST) begin
                    wd_abort   = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Command direction latch and beat counter (holds after the burst ends).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rw_lat     <= 1'b0;
            beat_count <= '0;
        end else if (accept) begin
            rw_lat     <= bus.RW;
            beat_count <= '0;
        end else if (beat_done) begin
            beat_count <= beat_next;
        end
    end

    // Key shift/compare while locked; idle expiry relocks and restarts key entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_sr  <= '0;
            key_cnt <= '0;
            active  <= 1'b0;
            mode    <= 1'b0;
        end else if (active) begin
            key_cnt <= '0;
            if (idle_expire) begin
                active <= 1'b0;
                mode   <= 1'b0;
                key_sr <= '0;
            end
        end else if (bus.ValidCmd) begin
            key_sr <= key_word;
            if (key_last) begin
                key_cnt <= '0;
                if (key_word == KEY_MODE0) begin
                    active <= 1'b1;
                    mode   <= 1'b0;
                end else if (key_word == KEY_MODE1) begin
                    active <= 1'b1;
                    mode   <= 1'b1;
                end
            end else begin
                key_cnt <= key_cnt + KCNT_W'(1);
            end
        end else begin
            key_cnt <= '0;
        end
    end

    // Single-cycle error pulse from a bad key or a watchdog abort.
    always_ff @(posedge Clk) begin
        if (Reset) error <= 1'b0;
        else       error <= key_mismatch || wd_abort;
    end

    generate
        if (IDLE_LIMIT > 0) begin : g_idle
            localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
            logic [IDLE_W-1:0] idle_cnt;

            assign idle_expire = active && (state == IDLE) && !bus.ValidCmd &&
                                 (idle_cnt == IDLE_LAST);

            // Consecutive idle cycles while unlocked; frozen during a burst.
            always_ff @(posedge Clk) begin
                if (Reset || !active || bus.ValidCmd || idle_expire) idle_cnt <= '0;
                else if (state == IDLE)                              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end else begin : g_no_idle
            assign idle_expire = 1'b0;
        end
    endgenerate

    assign bus.Busy         = (state != IDLE);
    assign bus.Active       = active;
    assign bus.Mode         = mode;
    assign bus.AccessMem    = (state == MEM);
    assign bus.RWMem        = (state == MEM) && rw_lat;
    assign bus.SampleData   = (state == SAMPLE);
    assign bus.TransferData = (state == XFER);
    assign bus.BeatCount    = beat_count;
    assign bus.Error        = error;
endmodule

// File: tb/tb_controller_burst.sv
// Self-checking bench for controller_burst (BURST_LEN=2, IDLE_LIMIT=5).
// Watchdog scenario follows CONTROLLER_BURST_WATCHDOG_EN when defined.
module tb_controller_burst;
    localparam int BL      = 2;
    localparam int IDLE_LIM = 5;
    localparam int TMO     = 16;
    localparam int CW      = $clog2(BL + 1);
    localparam int OW      = 8 + CW;
    localparam logic [3:0] K0 = 4'b1010;
    localparam logic [3:0] K1 = 4'b0101;

    typedef logic [OW-1:0] ovec_t;
    typedef struct {
        int kind;   // 0 idle, 1 sample, 2 mem, 3 xfer
        bit rw;
        int beat;
        bit vcmd;
        bit rwin;
        bit tdone;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    cyc_t stream[$];
    int   cur_beat;

    controller_burst_if #(.BURST_LEN(BL)) bus ();

    controller_burst #(
        .KEY_WIDTH(4), .KEY_MODE0(K0), .KEY_MODE1(K1), .BURST_LEN(BL),
        .IDLE_LIMIT(IDLE_LIM), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ovec_t outs();
        return {bus.Busy, bus.Active, bus.Mode, bus.AccessMem, bus.RWMem,
                bus.SampleData, bus.TransferData, bus.BeatCount, bus.Error};
    endfunction

    function automatic ovec_t mk(input bit busy, input bit act, input bit md, input bit mem,
                                 input bit rwm, input bit smp, input bit xf, input int beat,
                                 input bit err);
        return {busy, act, md, mem, rwm, smp, xf, CW'(beat), err};
    endfunction

    // Key outcome straight from the unlock rules: {Active, Mode, Error}.
    function automatic logic [2:0] key_model(input logic [3:0] k);
        if (k == K0) return 3'b100;
        if (k == K1) return 3'b110;
        return 3'b001;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.ValidCmd = 1'b0; bus.RW = 1'b0; bus.InputKey = 1'b0; bus.TransferDone = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic shift_key(input logic [3:0] k);
        for (int i = 3; i >= 0; i--) begin
            bus.ValidCmd = 1'b1;
            bus.InputKey = k[i];
            tick();
        end
        bus.ValidCmd = 1'b0;
        bus.InputKey = 1'($urandom);
    endtask

    task automatic add_gap(input int n);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            e = '{kind: 0, rw: 0, beat: cur_beat, vcmd: 0, rwin: 1'($urandom), tdone: 1'($urandom)};
            stream.push_back(e);
        end
    endtask

    task automatic add_cmd(input bit rw, input int dfix);
        cyc_t e;
        int   d;
        e = '{kind: 0, rw: 0, beat: cur_beat, vcmd: 1, rwin: rw, tdone: 1'($urandom)};
        stream.push_back(e);
        for (int b = 0; b < BL; b++) begin
            if (rw) begin
                e = '{kind: 1, rw: 1, beat: b, vcmd: 1'($urandom), rwin: 1'($urandom), tdone: 1'($urandom)};
                stream.push_back(e);
                e = '{kind: 2, rw: 1, beat: b, vcmd: 1'($urandom), rwin: 1'($urandom), tdone: 1'($urandom)};
                stream.push_back(e);
            end else begin
                e = '{kind: 2, rw: 0, beat: b, vcmd: 1'($urandom), rwin: 1'($urandom), tdone: 1'($urandom)};
                stream.push_back(e);
                d = (dfix > 0) ? dfix : int'($urandom_range(1, 4));
                for (int i = 0; i < d; i++) begin
                    e = '{kind: 3, rw: 0, beat: b, vcmd: 1'($urandom), rwin: 1'($urandom), tdone: (i == d - 1)};
                    stream.push_back(e);
                end
            end
        end
        cur_beat = BL;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            bus.ValidCmd = 1'b1; bus.InputKey = K0[i]; bus.RW = 1'($urandom);
            bus.TransferDone = 1'($urandom);
            tick();
            n_tests++;
            if (outs() !== '0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: outputs %b, expected %b", i, outs(), ovec_t'(0));
            end
        end
        rst = 1'b0;
        bus.ValidCmd = 1'b0;
        bus.TransferDone = 1'b0;
        tick();
        n_tests++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outputs %b, expected %b", outs(), ovec_t'(0));
        end
    endtask

    task automatic test_key_entry();
        logic [3:0] k;
        logic [2:0] obs;
        logic [2:0] exp;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            bus.ValidCmd = 1'b1; bus.InputKey = K0[i];
            tick();
            obs = {bus.Active, bus.Mode, bus.Error};
            exp = (i == 0) ? 3'b100 : 3'b000;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL key_mode0_bit%0d: {Active,Mode,Error}=%b expected %b", i, obs, exp);
            end
        end
        bus.ValidCmd = 1'b0;

        do_reset();
        shift_key(4'b1111);
        obs = {bus.Active, bus.Mode, bus.Error};
        n_tests++;
        if (obs !== 3'b001) begin
            n_fail++;
            $display("FAIL key_mismatch: {Active,Mode,Error}=%b expected 001", obs);
        end
        tick();
        obs = {bus.Active, bus.Mode, bus.Error};
        n_tests++;
        if (obs !== 3'b000) begin
            n_fail++;
            $display("FAIL key_error_one_cycle: {Active,Mode,Error}=%b expected 000", obs);
        end
        shift_key(K1);
        obs = {bus.Active, bus.Mode, bus.Error};
        n_tests++;
        if (obs !== 3'b110) begin
            n_fail++;
            $display("FAIL key_mode1_after_error: {Active,Mode,Error}=%b expected 110", obs);
        end

        // A gap restarts the count: 1,0,<gap>,1,0 is only two bits.
        do_reset();
        bus.ValidCmd = 1'b1; bus.InputKey = 1'b1; tick();
        bus.InputKey = 1'b0; tick();
        bus.ValidCmd = 1'b0; tick();
        bus.ValidCmd = 1'b1; bus.InputKey = 1'b1; tick();
        bus.InputKey = 1'b0; tick();
        bus.ValidCmd = 1'b0;
        obs = {bus.Active, bus.Mode, bus.Error};
        n_tests++;
        if (obs !== 3'b000) begin
            n_fail++;
            $display("FAIL key_gap: {Active,Mode,Error}=%b expected 000", obs);
        end

        for (int n = 0; n < 10; n++) begin
            do_reset();
            k = 4'($urandom);
            if (n == 0) k = K1;
            shift_key(k);
            obs = {bus.Active, bus.Mode, bus.Error};
            exp = key_model(k);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL key_random[%0d] key=%b: {Active,Mode,Error}=%b expected %b", n, k, obs, exp);
            end
        end
    endtask

    task automatic test_write_burst();
        ovec_t exp;
        bit    busy;
        do_reset();
        shift_key(K0);
        bus.ValidCmd = 1'b1; bus.RW = 1'b1;
        tick();
        for (int k = 1; k <= 2 * BL + 2; k++) begin
            busy = (k <= 2 * BL);
            exp = mk(busy, 1, 0, busy && (k % 2 == 0), busy && (k % 2 == 0),
                     busy && (k % 2 == 1), 0, ((k - 1) / 2 > BL) ? BL : (k - 1) / 2, 0);
            n_tests++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL write_burst t+%0d: outputs %b expected %b", k, outs(), exp);
            end
            bus.ValidCmd = busy ? 1'($urandom) : 1'b0;
            bus.RW = 1'($urandom);
            bus.TransferDone = 1'($urandom);
            tick();
        end
        bus.TransferDone = 1'b0;
    endtask

    task automatic test_read_burst();
        localparam int D = 3;
        ovec_t exp;
        int    b;
        int    o;
        bit    busy;
        do_reset();
        shift_key(K1);
        bus.ValidCmd = 1'b1; bus.RW = 1'b0;
        tick();
        for (int k = 1; k <= BL * (1 + D) + 2; k++) begin
            busy = (k <= BL * (1 + D));
            b = (k - 1) / (1 + D);
            o = (k - 1) % (1 + D);
            exp = busy ? mk(1, 1, 1, o == 0, 0, 0, o != 0, b, 0) : mk(0, 1, 1, 0, 0, 0, 0, BL, 0);
            n_tests++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL read_burst t+%0d: outputs %b expected %b", k, outs(), exp);
            end
            bus.ValidCmd = busy ? 1'($urandom) : 1'b0;
            bus.RW = 1'($urandom);
            bus.TransferDone = (busy && o != 0) ? (o == D) : 1'($urandom);
            tick();
        end
        bus.TransferDone = 1'b0;
    endtask

    task automatic test_back_to_back();
        cyc_t  e;
        ovec_t exp;
        bit    md;
        do_reset();
        md = 1'($urandom);
        shift_key(md ? K1 : K0);
        stream.delete();
        cur_beat = 0;
        for (int c = 0; c < 8; c++) begin
            add_gap(int'($urandom_range(0, 3)));
            add_cmd(1'($urandom), 0);
        end
        add_gap(2);
        for (int i = 0; i < stream.size(); i++) begin
            e = stream[i];
            exp = mk(e.kind != 0, 1, md, e.kind == 2, e.kind == 2 && e.rw, e.kind == 1,
                     e.kind == 3, e.beat, 0);
            n_tests++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: outputs %b expected %b", i, outs(), exp);
            end
            bus.ValidCmd = e.vcmd;
            bus.RW = e.rwin;
            bus.TransferDone = e.tdone;
            tick();
        end
        bus.ValidCmd = 1'b0;
        bus.TransferDone = 1'b0;
    endtask

    task automatic test_idle_timeout();
        logic [1:0] obs;
        logic [1:0] exp;
        int  idle_run;
        bit  vcmd;
        bit  busy;
        do_reset();
        shift_key(K1);
        for (int j = 1; j <= 7; j++) begin
            obs = {bus.Active, bus.Mode};
            exp = (j <= IDLE_LIM) ? 2'b11 : 2'b00;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL idle_expire idle%0d: {Active,Mode}=%b expected %b", j, obs, exp);
            end
            tick();
        end
        shift_key(K0);
        obs = {bus.Active, bus.Mode};
        n_tests++;
        if (obs !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_rekey: {Active,Mode}=%b expected 10", obs);
        end
        idle_run = 0;
        for (int c = 1; c <= 4 + 2 * BL + 7; c++) begin
            n_tests++;
            if (bus.Active !== (idle_run < IDLE_LIM)) begin
                n_fail++;
                $display("FAIL idle_cmd c%0d: Active=%b expected %b", c, bus.Active, idle_run < IDLE_LIM);
            end
            vcmd = (c == 4);
            busy = (c > 4) && (c <= 4 + 2 * BL);
            bus.ValidCmd = vcmd;
            bus.RW = 1'b1;
            if (vcmd)       idle_run = 0;
            else if (!busy) idle_run++;
            tick();
        end
        bus.ValidCmd = 1'b0;
    endtask

    task automatic test_watchdog();
        ovec_t exp;
        do_reset();
        shift_key(K0);
        bus.ValidCmd = 1'b1; bus.RW = 1'b0;
        tick();
        bus.ValidCmd = 1'b0;
        bus.TransferDone = 1'b0;
`ifdef CONTROLLER_BURST_WATCHDOG_EN
        for (int k = 1; k <= TMO + 3; k++) begin
            if (k == 1)             exp = mk(1, 1, 0, 1, 0, 0, 0, 0, 0);
            else if (k <= TMO + 1)  exp = mk(1, 1, 0, 0, 0, 0, 1, 0, 0);
            else if (k == TMO + 2)  exp = mk(0, 1, 0, 0, 0, 0, 0, 0, 1);
            else                    exp = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
            n_tests++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL watchdog t+%0d: outputs %b expected %b", k, outs(), exp);
            end
            tick();
        end
`else
        for (int k = 1; k <= 41; k++) begin
            if (k == 1)       exp = mk(1, 1, 0, 1, 0, 0, 0, 0, 0);
            else if (k <= 40) exp = mk(1, 1, 0, 0, 0, 0, 1, 0, 0);
            else              exp = mk(1, 1, 0, 1, 0, 0, 0, 1, 0);
            n_tests++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL no_watchdog t+%0d: outputs %b expected %b", k, outs(), exp);
            end
            bus.TransferDone = (k == 40);
            tick();
        end
        bus.TransferDone = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        shift_key(K1);
        bus.ValidCmd = 1'b1; bus.RW = 1'b0;
        tick();
        bus.ValidCmd = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.TransferData !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_xfer_setup: TransferData=%b expected 1", bus.TransferData);
        end
        rst = 1'b1;
        bus.ValidCmd = 1'($urandom);
        bus.TransferDone = 1'b0;
        tick();
        n_tests++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_xfer: outputs %b expected %b", outs(), ovec_t'(0));
        end
        rst = 1'b0;
        bus.ValidCmd = 1'b0;
        tick();
        n_tests++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_xfer_after: outputs %b expected %b", outs(), ovec_t'(0));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ValidCmd = 1'b0; bus.RW = 1'b0; bus.InputKey = 1'b0; bus.TransferDone = 1'b0;
        test_reset();
        test_key_entry();
        test_write_burst();
        test_read_burst();
        test_back_to_back();
        test_idle_timeout();
        test_watchdog();
        test_reset_mid_xfer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/controller_burst.md
Name: controller_burst

Overview:
- Parametrised next-generation memory/transceiver controller.
- Unlocks on a serially entered multi-bit key, which also selects one of two modes.
- Once active, sequences read and write commands as BURST_LEN-beat bursts across the memory and transceiver strobes.
- Adds features the previous controller lacks: key mismatch error, idle auto-deactivation, beat counting and an optional transfer watchdog.

Parameters:
- KEY_WIDTH, 4: number of key bits shifted in on InputKey.
- KEY_MODE0, 4'b1010: key that activates with Mode=0.
- KEY_MODE1, 4'b0101: key that activates with Mode=1.
- BURST_LEN, 1: beats per command, >=1.
- IDLE_LIMIT, 0: idle cycles before auto-deactivation; 0 disables it.
- TIMEOUT_CYCLES, 16: watchdog limit in XFER (used only with the macro).
- CNT_W (localparam): $clog2(BURST_LEN+1).

Ports:
- Clk  in  1  system clock; all state is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ValidCmd  in  1  key bit valid while inactive; command request while active.
- RW  in  1  command direction, 1=write, 0=read; sampled when a command is accepted.
- InputKey  in  1  serial key bit, MSB first.
- TransferDone  in  1  transceiver done; honoured only in XFER.
- Busy  out  1  transaction in progress.
- Active  out  1  controller unlocked.
- Mode  out  1  mode selected by the matched key.
- AccessMem  out  1  memory access strobe.
- RWMem  out  1  memory direction, 1=write; meaningful only when AccessMem=1.
- SampleData  out  1  transceiver sample strobe (write path).
- TransferData  out  1  transceiver transfer request (read path).
- BeatCount  out  CNT_W  beats completed in the current or last burst.
- Error  out  1  one-cycle pulse on key mismatch or watchdog abort.

Behaviour:
- Reset: all outputs 0, Active=0, Mode=0, FSM=IDLE, key shift register and bit counter cleared. Reset overrides any operation in progress.
- Key entry (Active=0):
  - Each cycle with ValidCmd=1 shifts InputKey into the shift register and increments the bit counter.
  - A cycle with ValidCmd=0 clears the counter; key bits must be contiguous.
  - On the KEY_WIDTH-th bit, compare the full word (including the current bit):
    - Equal to KEY_MODE0: Active=1, Mode=0 on the next cycle.
    - Else equal to KEY_MODE1: Active=1, Mode=1 on the next cycle.
    - Else: Error=1 for one cycle.
  - The counter clears after every comparison. If KEY_MODE0==KEY_MODE1, mode 0 wins.
- Command accept: FSM in IDLE, Active=1, ValidCmd=1 at cycle t.
  - RW is latched, BeatCount is set to 0, Busy=1 from t+1.
  - ValidCmd and RW are ignored while Busy=1.
- FSM states: IDLE, SAMPLE, MEM, XFER. All strobes are decoded from the registered state.
- Write beat: SAMPLE (SampleData=1, 1 cycle), then MEM (AccessMem=1, RWMem=1, 1 cycle).
  - At the end of MEM, BeatCount increments.
  - If the new count < BURST_LEN, go to SAMPLE; otherwise go to IDLE.
- Read beat: MEM (AccessMem=1, RWMem=0, 1 cycle), then XFER (TransferData=1 held).
  - XFER exits on the cycle TransferDone=1 is sampled, including the first XFER cycle.
  - On exit, BeatCount increments; go to MEM if beats remain, otherwise IDLE.
- Busy=0 in IDLE.
  - Write burst: Busy is high for 2*BURST_LEN cycles.
  - Read burst: Busy is high for BURST_LEN*(1+XFER cycles).
- BeatCount holds its final value until the next accept or Reset.
- Idle deactivation (IDLE_LIMIT>0):
  - The counter runs while Active=1, FSM=IDLE and ValidCmd=0.
  - It clears on any ValidCmd=1.
  - On reaching IDLE_LIMIT: Active=0, Mode=0 next cycle, and key entry restarts.
  - The counter never runs while Busy=1.
- Simultaneous events:
  - TransferDone outside XFER is ignored.
  - ValidCmd on the same cycle the FSM returns to IDLE is ignored; it is accepted only while already in IDLE.

Optional Feature:
- Macro: CONTROLLER_BURST_WATCHDOG_EN.
- Defined: a counter runs in XFER and clears on each XFER entry. If TIMEOUT_CYCLES consecutive XFER cycles pass without TransferDone:
  - Error=1 for one cycle and the FSM goes to IDLE (Busy=0).
  - BeatCount is not incremented.
  - Active and Mode are unchanged.
- Undefined: XFER waits for TransferDone indefinitely, no watchdog logic is built, and Error comes only from key mismatch.

Test Plan:
- Reset, then shift 1,0,1,0 with ValidCmd=1 on 4 consecutive cycles -> Active=1, Mode=0 one cycle after the 4th bit; Error stays 0.
- Shift 1,1,1,1 -> Error=1 for exactly one cycle, Active stays 0. Then shift 0,1,0,1 -> Active=1, Mode=1.
- Active, BURST_LEN=2, ValidCmd=1 with RW=1 at t -> SampleData at t+1 and t+3, AccessMem&RWMem at t+2 and t+4, Busy t+1..t+4, BeatCount=2 at t+5.
- Active, BURST_LEN=1, read at t, TransferDone=1 at t+4 -> AccessMem=1/RWMem=0 at t+1, TransferData t+2..t+4, Busy=0 at t+5.
- IDLE_LIMIT=5, active and idle -> Active=0 after 5 idle cycles. A command at the 4th idle cycle -> Active stays 1.
- Watchdog macro, TIMEOUT_CYCLES=16, read with no TransferDone -> Error pulse after 16 XFER cycles, Busy=0, BeatCount=0. Separately, Reset asserted mid-XFER -> all outputs 0 the next cycle.
